// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx_arbiter slice.
// The state encoding is exported so checkers can decode the debug state output.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester and utx-side signals of uart_tx_arbiter.
// The master modport is the application/utx side; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  import uart_arb_pkg::*;

  // Handshakes: req[i] is a level held with req_data byte i until ack[i] pulses
  // (one cycle, byte taken) or the requester withdraws it. Toward utx, send is
  // held until rdy falls (byte accepted), then dropped until rdy rises (idle).
  logic [N-1:0]        req;
  logic [N*BYTE_W-1:0] req_data;
  logic [N-1:0]        ack;
  logic                tx_send;
  logic [BYTE_W-1:0]   tx_data;
  logic                tx_rdy;
  logic                busy;
  logic [IDW-1:0]      owner;
  logic                timeout_err;
  state_t              dbg_state;

  modport master (
    output req, req_data, tx_rdy,
    input  ack, tx_send, tx_data, busy, owner, timeout_err, dbg_state
  );

  modport slave (
    input  req, req_data, tx_rdy,
    output ack, tx_send, tx_data, busy, owner, timeout_err, dbg_state
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] j;

  // Scan from the farthest candidate inward so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one utx byte transmitter among N requesters,
// sequencing the send/rdy handshake with an accept timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N              = 4,
  parameter int IDW            = $clog2(N),
  parameter int ACCEPT_TIMEOUT = 1024
) (
  input logic              CLK,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int CW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

  state_t            state, state_n;
  logic [IDW-1:0]    ptr;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      ack_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [IDW-1:0]    owner_q;
  logic              terr_q;
  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;
  logic              grant;
  logic              cnt_done;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign grant    = (state == IDLE) && bus.tx_rdy && pick_valid;
  assign cnt_done = (cnt == CW'(ACCEPT_TIMEOUT - 1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = SEND;
      SEND:    if (!bus.tx_rdy || cnt_done) state_n = DRAIN;
      DRAIN:   if (bus.tx_rdy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant-time capture; tx_data and owner only change on IDLE->SEND.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr       <= IDW'(N - 1);
      cnt       <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      owner_q   <= '0;
      terr_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      if (grant) begin
        ack_q[pick_idx] <= 1'b1;
        tx_data_q       <= bus.req_data[int'(pick_idx)*BYTE_W +: BYTE_W];
        owner_q         <= pick_idx;
        ptr             <= pick_idx;
        cnt             <= '0;
      end else if (state == SEND) begin
        cnt <= cnt + CW'(1);
        // A falling rdy on the last cycle still counts as accepted.
        if (cnt_done && bus.tx_rdy) terr_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.tx_send     = (state == SEND);
    bus.busy        = (state != IDLE);
    bus.ack         = ack_q;
    bus.tx_data     = tx_data_q;
    bus.owner       = owner_q;
    bus.timeout_err = terr_q;
    bus.dbg_state   = state;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N=4, ACCEPT_TIMEOUT=16).
// The bench plays the utx rdy side by hand and predicts every output value.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.N(N), .IDW(IDW), .ACCEPT_TIMEOUT(TO)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_ack_q[$];

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // rdy falls (byte accepted) then rises (line idle); arbiter returns to IDLE.
  task automatic finish_byte(input string tag);
    bus.tx_rdy = 1'b0;
    tick();
    check({tag, "_send_low"}, bus.tx_send, 0);
    bus.tx_rdy = 1'b1;
    tick();
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    logic [3:0] a;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_rdy   = 1'b1;

    // Reset values before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_terr", bus.timeout_err, 0);
    check("rst_state", bus.dbg_state, IDLE);
    tick();
    reset = 1'b0;

    // Single request from requester 2.
    bus.req_data = {8'h00, 8'h41, 8'h00, 8'h00};
    bus.req      = 4'b0100;
    check("single_pre_ack", bus.ack, 0);
    tick();
    check("single_ack", bus.ack, 4'b0100);
    check("single_data", bus.tx_data, 8'h41);
    check("single_send", bus.tx_send, 1);
    check("single_owner", bus.owner, 2);
    bus.req = '0;
    tick();
    check("single_ack_pulse", bus.ack, 0);
    check("single_send_hold", bus.tx_send, 1);
    tick();
    bus.tx_rdy = 1'b0;
    tick();
    check("single_send_drop", bus.tx_send, 0);
    check("single_busy_drain", bus.busy, 1);
    check("single_state_drain", bus.dbg_state, DRAIN);
    bus.tx_rdy = 1'b1;
    tick();
    check("single_busy_idle", bus.busy, 0);
    check("single_data_stable", bus.tx_data, 8'h41);

    // Fairness: all four requesters held, grant order 0,1,2,3,0.
    do_reset();
    bus.req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    exp_q        = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
    exp_ack_q    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req      = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (bus.ack == 0 && n < 8) begin
        check("fair_gap_ack", bus.ack, 0);
        tick();
        n++;
      end
      d = exp_q.pop_front();
      a = exp_ack_q.pop_front();
      check("fair_ack", bus.ack, a);
      check("fair_data", bus.tx_data, d);
      finish_byte("fair");
      check("fair_data_hold", bus.tx_data, d);
    end
    bus.req = '0;

    // Not ready: no grant while tx_rdy is low.
    do_reset();
    bus.tx_rdy   = 1'b0;
    bus.req_data = {8'h00, 8'h00, 8'h5a, 8'h00};
    bus.req      = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("nrdy_ack", bus.ack, 0);
      check("nrdy_send", bus.tx_send, 0);
    end
    bus.tx_rdy = 1'b1;
    tick();
    check("nrdy_grant_ack", bus.ack, 4'b0010);
    check("nrdy_grant_data", bus.tx_data, 8'h5a);
    bus.req = '0;
    finish_byte("nrdy");

    // Timeout: rdy never falls, send held for TO cycles then abandoned.
    do_reset();
    bus.req_data = {8'h00, 8'h00, 8'h66, 8'h55};
    bus.req      = 4'b0001;
    tick();
    check("to_ack", bus.ack, 4'b0001);
    bus.req = '0;
    n = 0;
    while (bus.tx_send && n < 100) begin
      n++;
      tick();
    end
    check("to_send_cycles", n, TO);
    check("to_err_set", bus.timeout_err, 1);
    check("to_state_drain", bus.dbg_state, DRAIN);
    tick();
    check("to_idle", bus.busy, 0);
    bus.req = 4'b0010;
    tick();
    check("to_next_ack", bus.ack, 4'b0010);
    check("to_next_data", bus.tx_data, 8'h66);
    bus.req = '0;
    finish_byte("to_next");
    check("to_err_sticky", bus.timeout_err, 1);

    // Asynchronous reset in the middle of SEND.
    bus.req_data = {8'h0d, 8'h00, 8'h77, 8'h0a};
    bus.req      = 4'b0100;
    tick();
    check("mid_send_up", bus.tx_send, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_send", bus.tx_send, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_terr", bus.timeout_err, 0);
    #2 reset = 1'b0;
    bus.req = 4'b1001;
    tick();
    check("post_rst_ack", bus.ack, 4'b0001);
    check("post_rst_owner", bus.owner, 0);
    check("post_rst_data", bus.tx_data, 8'h0a);
    finish_byte("post_rst");
    tick();
    check("post_rst_second", bus.ack, 4'b1000);
    check("post_rst_second_data", bus.tx_data, 8'h0d);
    bus.req = '0;
    finish_byte("post_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
